// File: rtl/spm_dma_pkg.sv
// spm_dma_pkg: shared widths, direction constants and FSM state encoding for spm_dma
package spm_dma_pkg;
   localparam int BUS_ADDR_W = 30;
   localparam int DATA_W     = 32;
   localparam int SPM_ADDR_W = 12;
   localparam int CNT_W      = SPM_ADDR_W + 1;
   localparam logic DIR_BUS2SPM = 1'b0;
   localparam logic DIR_SPM2BUS = 1'b1;
   localparam logic BUS_READ    = 1'b1;
   typedef enum logic [2:0] {
      ST_IDLE,
      ST_REQ,
      ST_SPM_RD,
      ST_SPM_CAP,
      ST_BUS_ACC,
      ST_SPM_WR,
      ST_ADV,
      ST_DONE
   } state_e;
endpackage

// File: rtl/spm_dma.sv
// spm_dma: block copy engine between the system bus and SPM port B, one word at a time
module spm_dma
   import spm_dma_pkg::*;
(
   input  logic                  clk,
   input  logic                  reset,
   input  logic                  start,
   input  logic                  dir,
   input  logic [BUS_ADDR_W-1:0] bus_base,
   input  logic [SPM_ADDR_W-1:0] spm_base,
   input  logic [CNT_W-1:0]      count,
   input  logic                  abort,
   output logic                  busy,
   output logic                  done,
   output logic                  aborted,
   output logic [CNT_W-1:0]      remaining,
   output logic                  bus_req_,
   input  logic                  bus_grnt_,
   output logic                  bus_as_,
   output logic                  bus_rw,
   output logic [BUS_ADDR_W-1:0] bus_addr,
   output logic [DATA_W-1:0]     bus_wr_data,
   input  logic [DATA_W-1:0]     bus_rd_data,
   input  logic                  bus_rdy_,
   output logic [SPM_ADDR_W-1:0] spm_addr,
   output logic                  spm_we,
   output logic [DATA_W-1:0]     spm_wr_data,
   input  logic [DATA_W-1:0]     spm_rd_data
);
   state_e                state_q, state_d;
   logic                  dir_q, dir_d;
   logic [BUS_ADDR_W-1:0] bus_ptr_q, bus_ptr_d;
   logic [SPM_ADDR_W-1:0] spm_ptr_q, spm_ptr_d;
   logic [CNT_W-1:0]      rem_q, rem_d;
   logic                  abort_q, abort_d;
   logic                  aborted_q, aborted_d;
   logic [DATA_W-1:0]     bus_wr_data_q, bus_wr_data_d;
   logic [DATA_W-1:0]     spm_wr_data_q, spm_wr_data_d;

   assign busy        = (state_q != ST_IDLE) && (state_q != ST_DONE);
   assign done        = state_q == ST_DONE;
   assign aborted     = aborted_q;
   assign remaining   = rem_q;
   assign bus_req_    = ~busy;
   assign bus_as_     = state_q != ST_BUS_ACC;
   assign bus_rw      = (state_q == ST_BUS_ACC) ? ~dir_q : BUS_READ;
   assign bus_addr    = bus_ptr_q;
   assign bus_wr_data = bus_wr_data_q;
   assign spm_addr    = spm_ptr_q;
   assign spm_we      = state_q == ST_SPM_WR;
   assign spm_wr_data = spm_wr_data_q;

   // next state, pointer/count updates and data capture for the per-word sequence
   always_comb begin
      state_d       = state_q;
      dir_d         = dir_q;
      bus_ptr_d     = bus_ptr_q;
      spm_ptr_d     = spm_ptr_q;
      rem_d         = rem_q;
      abort_d       = abort_q | (busy & abort);
      aborted_d     = aborted_q;
      bus_wr_data_d = bus_wr_data_q;
      spm_wr_data_d = spm_wr_data_q;
      case (state_q)
         ST_IDLE: if (start) begin
            dir_d     = dir;
            bus_ptr_d = bus_base;
            spm_ptr_d = spm_base;
            rem_d     = count;
            abort_d   = 1'b0;
            aborted_d = 1'b0;
            state_d   = (count == '0) ? ST_DONE : ST_REQ;
         end
         ST_REQ: if (!bus_grnt_) state_d = (dir_q == DIR_SPM2BUS) ? ST_SPM_RD : ST_BUS_ACC;
         ST_SPM_RD: state_d = ST_SPM_CAP;
         ST_SPM_CAP: begin
            bus_wr_data_d = spm_rd_data;
            state_d       = ST_BUS_ACC;
         end
         ST_BUS_ACC: if (!bus_rdy_) begin
            spm_wr_data_d = (dir_q == DIR_BUS2SPM) ? bus_rd_data : spm_wr_data_q;
            state_d       = (dir_q == DIR_SPM2BUS) ? ST_ADV : ST_SPM_WR;
         end
         ST_SPM_WR: state_d = ST_ADV;
         ST_ADV: begin
            bus_ptr_d = bus_ptr_q + 1'b1;
            spm_ptr_d = spm_ptr_q + 1'b1;
            rem_d     = rem_q - 1'b1;
            if (rem_d == '0 || abort_q || abort) begin
               aborted_d = rem_d != '0;
               state_d   = ST_DONE;
            end else begin
               state_d = (dir_q == DIR_SPM2BUS) ? ST_SPM_RD : ST_BUS_ACC;
            end
         end
         ST_DONE: state_d = ST_IDLE;
         default: state_d = ST_IDLE;
      endcase
   end

   // state and datapath registers, cleared asynchronously so the bus is released at once
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state_q       <= ST_IDLE;
         dir_q         <= DIR_BUS2SPM;
         bus_ptr_q     <= '0;
         spm_ptr_q     <= '0;
         rem_q         <= '0;
         abort_q       <= 1'b0;
         aborted_q     <= 1'b0;
         bus_wr_data_q <= '0;
         spm_wr_data_q <= '0;
      end else begin
         state_q       <= state_d;
         dir_q         <= dir_d;
         bus_ptr_q     <= bus_ptr_d;
         spm_ptr_q     <= spm_ptr_d;
         rem_q         <= rem_d;
         abort_q       <= abort_d;
         aborted_q     <= aborted_d;
         bus_wr_data_q <= bus_wr_data_d;
         spm_wr_data_q <= spm_wr_data_d;
      end
   end
endmodule

// File: tb/tb_spm_dma.sv
// tb_spm_dma: randomized transfers against a word-list reference model of the copy engine
module tb_spm_dma;
   import spm_dma_pkg::*;
   logic                  clk = 1'b0;
   logic                  reset = 1'b1;
   logic                  start = 1'b0;
   logic                  dir = 1'b0;
   logic                  abort = 1'b0;
   logic [BUS_ADDR_W-1:0] bus_base = '0;
   logic [SPM_ADDR_W-1:0] spm_base = '0;
   logic [CNT_W-1:0]      count = '0;
   logic                  busy, done, aborted;
   logic [CNT_W-1:0]      remaining;
   logic                  bus_req_, bus_grnt_, bus_as_, bus_rw, bus_rdy_;
   logic [BUS_ADDR_W-1:0] bus_addr;
   logic [DATA_W-1:0]     bus_wr_data, bus_rd_data;
   logic [SPM_ADDR_W-1:0] spm_addr;
   logic                  spm_we;
   logic [DATA_W-1:0]     spm_wr_data, spm_rd_data;
   logic [DATA_W-1:0]     ram [0:4095];
   logic [DATA_W-1:0]     ref_spm [0:4095];
   logic [63:0]           spm_wq[$], bus_wq[$], exp_q[$];
   int                    wait_n = 0, wcnt = 0, req_cycles = 0;
   int                    errors = 0, checks = 0;

   spm_dma dut (
      .clk(clk), .reset(reset), .start(start), .dir(dir), .bus_base(bus_base),
      .spm_base(spm_base), .count(count), .abort(abort), .busy(busy), .done(done),
      .aborted(aborted), .remaining(remaining), .bus_req_(bus_req_), .bus_grnt_(bus_grnt_),
      .bus_as_(bus_as_), .bus_rw(bus_rw), .bus_addr(bus_addr), .bus_wr_data(bus_wr_data),
      .bus_rd_data(bus_rd_data), .bus_rdy_(bus_rdy_), .spm_addr(spm_addr), .spm_we(spm_we),
      .spm_wr_data(spm_wr_data), .spm_rd_data(spm_rd_data)
   );

   always #5 clk = ~clk;

   function automatic logic [DATA_W-1:0] bword(input logic [BUS_ADDR_W-1:0] a);
      return {a[15:0], ~a[29:14]} ^ 32'h5A3C_96E1;
   endfunction

   assign bus_grnt_   = bus_req_;
   assign bus_rd_data = bword(bus_addr);
   assign bus_rdy_    = !(!bus_as_ && wcnt >= wait_n);

   always @(posedge clk) begin
      spm_rd_data <= ram[spm_addr];
      if (spm_we) begin
         ram[spm_addr] <= spm_wr_data;
         spm_wq.push_back({20'b0, spm_addr, spm_wr_data});
      end
      if (!bus_as_ && !bus_rdy_ && !bus_rw) bus_wq.push_back({2'b0, bus_addr, bus_wr_data});
      wcnt <= (bus_as_ || !bus_rdy_) ? 0 : wcnt + 1;
      if (!bus_req_) req_cycles <= req_cycles + 1;
   end

   task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   task automatic run(input logic d, input logic [BUS_ADDR_W-1:0] bb, input logic [SPM_ADDR_W-1:0] sb,
                      input int n, input int w, input int ab, input int rs);
      int m, cyc, strobes, lat;
      logic prev_as;
      logic [BUS_ADDR_W-1:0] ba;
      logic [SPM_ADDR_W-1:0] sa;
      logic [63:0] got_q[$];
      m = (ab > 0 && ab < n) ? ab : n;
      exp_q.delete();
      for (int i = 0; i < m; i++) begin
         ba = bb + BUS_ADDR_W'(i);
         sa = sb + SPM_ADDR_W'(i);
         if (d == DIR_BUS2SPM) begin
            ref_spm[sa] = bword(ba);
            exp_q.push_back({20'b0, sa, bword(ba)});
         end else begin
            exp_q.push_back({2'b0, ba, ref_spm[sa]});
         end
      end
      lat = (n == 0) ? 0 : 1 + m * ((d == DIR_SPM2BUS ? 4 : 3) + w);
      wait_n = w;
      spm_wq.delete();
      bus_wq.delete();
      req_cycles = 0;
      @(negedge clk);
      dir = d; bus_base = bb; spm_base = sb; count = CNT_W'(n); start = 1'b1;
      @(negedge clk);
      start = 1'b0; cyc = 0; strobes = 0; prev_as = 1'b1;
      check("busy_after_start", busy, n != 0);
      while (!done && cyc < 20000) begin
         if (cyc == rs) begin
            start = 1'b1; dir = ~d; count = CNT_W'(5);
         end else begin
            start = 1'b0;
         end
         if (!bus_as_ && prev_as) strobes++;
         abort = ab > 0 && !bus_as_ && prev_as && strobes == ab;
         prev_as = bus_as_;
         @(negedge clk);
         cyc++;
      end
      start = 1'b0; abort = 1'b0;
      check("done_seen", done, 1);
      check("latency", cyc, lat);
      check("aborted", aborted, m != n);
      check("remaining", remaining, n - m);
      check("busy_in_done", busy, 0);
      got_q = (d == DIR_SPM2BUS) ? bus_wq : spm_wq;
      check("word_count", got_q.size(), m);
      check("other_side_writes", (d == DIR_SPM2BUS) ? spm_wq.size() : bus_wq.size(), 0);
      for (int i = 0; i < exp_q.size(); i++) check("word", (i < got_q.size()) ? got_q[i] : '1, exp_q[i]);
      @(negedge clk);
      check("done_pulse", done, 0);
      check("idle_busy", busy, 0);
      check("req_released", bus_req_, 1);
      if (n == 0) check("no_req_count0", req_cycles, 0);
   endtask

   initial begin
      int cyc, dones, bad, n, ab;
      for (int i = 0; i < 4096; i++) begin
         ram[i] = $urandom;
         ref_spm[i] = ram[i];
      end
      #2 reset = 1'b0;
      repeat (2) @(negedge clk);
      check("rst_busy", busy, 0);
      check("rst_done", done, 0);
      check("rst_aborted", aborted, 0);
      check("rst_remaining", remaining, 0);
      check("rst_req", bus_req_, 1);
      check("rst_as", bus_as_, 1);
      check("rst_rw", bus_rw, 1);
      check("rst_bus_addr", bus_addr, 0);
      check("rst_spm_we", spm_we, 0);
      check("rst_spm_addr", spm_addr, 0);
      check("rst_bus_wr_data", bus_wr_data, 0);
      check("rst_spm_wr_data", spm_wr_data, 0);
      reset = 1'b1;
      run(DIR_BUS2SPM, 30'h100, 12'h010, 4, 0, 0, -1);
      run(DIR_SPM2BUS, 30'h200, 12'h020, 3, 2, 0, -1);
      run(DIR_BUS2SPM, 30'h300, 12'hFFE, 4, 1, 0, -1);
      run(DIR_BUS2SPM, 30'h400, 12'h100, 8, 0, 2, -1);
      run(DIR_SPM2BUS, 30'h500, 12'h200, 8, 1, 2, -1);
      run(DIR_BUS2SPM, 30'h600, 12'h300, 0, 0, 0, -1);
      run(DIR_SPM2BUS, 30'h700, 12'h300, 6, 0, 0, 4);
      run(DIR_SPM2BUS, 30'h3FFF_FFFE, 12'h7F0, 4, 0, 0, -1);
      for (int k = 0; k < 8; k++) begin
         n = $urandom_range(1, 20);
         ab = (n > 1 && $urandom_range(0, 2) == 0) ? $urandom_range(1, n - 1) : 0;
         run(1'($urandom_range(0, 1)), BUS_ADDR_W'($urandom), SPM_ADDR_W'($urandom), n,
             $urandom_range(0, 3), ab, $urandom_range(0, 1) == 1 ? 3 : -1);
      end
      wait_n = 0;
      @(negedge clk);
      dir = DIR_BUS2SPM; bus_base = 30'h900; spm_base = 12'h500; count = CNT_W'(4); start = 1'b1;
      @(negedge clk);
      start = 1'b0; cyc = 0;
      while (!spm_we && cyc < 100) begin
         @(negedge clk);
         cyc++;
      end
      check("reached_spm_wr", spm_we, 1);
      reset = 1'b0;
      #1;
      check("rst_mid_spm_we", spm_we, 0);
      check("rst_mid_busy", busy, 0);
      check("rst_mid_req", bus_req_, 1);
      check("rst_mid_as", bus_as_, 1);
      check("rst_mid_remaining", remaining, 0);
      @(negedge clk);
      reset = 1'b1;
      dones = 0;
      repeat (6) begin
         @(negedge clk);
         if (done) dones++;
      end
      check("no_done_after_reset", dones, 0);
      check("idle_after_reset", busy, 0);
      bad = 0;
      for (int i = 0; i < 4096; i++) if (ram[i] !== ref_spm[i]) bad++;
      check("spm_image", bad, 0);
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end
endmodule
